// File: rtl/nn_stream_player_if.sv
`default_nettype none
// ============================================================================
//  Module   : nn_stream_player_if
//  Purpose  : Buffer-write, control and output-stream signals of the
//             nn_stream_player, bundled with driver/player modports.
//  Revision : 1.0  initial release
// ============================================================================
interface nn_stream_player_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int CNTW  = 16
);
  localparam int AW = $clog2(DEPTH);

  logic             wr_vld;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             start;
  logic             abort;
  logic [AW:0]      length;
  logic [CNTW-1:0]  repeat_cnt;
  logic [WIDTH-1:0] out_data;
  logic             out_vld;
  logic             out_rdy;
  logic             out_fst;
  logic             out_lst;
  logic             busy;
  logic             done;
  logic [CNTW-1:0]  pass_cnt;

  // Side that loads the buffer, controls playback and consumes the stream
  modport master (
    output wr_vld, wr_addr, wr_data, start, abort, length, repeat_cnt, out_rdy,
    input  out_data, out_vld, out_fst, out_lst, busy, done, pass_cnt
  );

  // The player itself
  modport slave (
    input  wr_vld, wr_addr, wr_data, start, abort, length, repeat_cnt, out_rdy,
    output out_data, out_vld, out_fst, out_lst, busy, done, pass_cnt
  );
endinterface
`default_nettype wire

// File: rtl/nn_stream_player.sv
`default_nettype none
// ============================================================================
//  Module   : nn_stream_player
//  Purpose  : Loadable word buffer replayed as a valid/ready stream with
//             first/last markers, pass counting, continuous mode and abort.
//  Revision : 1.0  initial release
// ============================================================================
module nn_stream_player #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int CNTW  = 16
) (
  input  logic              clk,
  input  logic              reset,
  nn_stream_player_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      len_q, len_d;
  logic [CNTW-1:0]  rep_q, rep_d;
  logic [CNTW-1:0]  lpass_q, lpass_d;     // passes whose last word has been loaded
  logic [CNTW-1:0]  pass_cnt_q, pass_cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_vld_q, out_vld_d;
  logic             out_fst_q, out_fst_d;
  logic             out_lst_q, out_lst_d;
  logic             done_q, done_d;

  logic             xfer;
  logic             load;
  logic             at_last;
  logic             len_ok;

  assign xfer    = out_vld_q & bus.out_rdy;
  assign load    = ~out_vld_q | bus.out_rdy;
  assign at_last = ({1'b0, rd_ptr_q} == (len_q - (AW+1)'(1)));
  assign len_ok  = (bus.length != '0) && (bus.length <= (AW+1)'(DEPTH));

  // Buffer write port; not reset. Reads use the pre-edge contents, so a
  // same-address read/write in one cycle returns the old word.
  always_ff @(posedge clk) begin
    if (bus.wr_vld) mem_q[bus.wr_addr] <= bus.wr_data;
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rd_ptr_q   <= '0;
      len_q      <= '0;
      rep_q      <= '0;
      lpass_q    <= '0;
      pass_cnt_q <= '0;
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
      out_fst_q  <= 1'b0;
      out_lst_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      len_q      <= len_d;
      rep_q      <= rep_d;
      lpass_q    <= lpass_d;
      pass_cnt_q <= pass_cnt_d;
      out_data_q <= out_data_d;
      out_vld_q  <= out_vld_d;
      out_fst_q  <= out_fst_d;
      out_lst_q  <= out_lst_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic: playback sequencing, pass counting and abort override
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    len_d      = len_q;
    rep_d      = rep_q;
    lpass_d    = lpass_q;
    pass_cnt_d = pass_cnt_q;
    out_data_d = out_data_q;
    out_vld_d  = out_vld_q;
    out_fst_d  = out_fst_q;
    out_lst_d  = out_lst_q;
    done_d     = 1'b0;

    // A transfer counts even when abort arrives in the same cycle
    if (xfer && out_lst_q) pass_cnt_d = pass_cnt_q + CNTW'(1);

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort && len_ok) begin
          len_d      = bus.length;
          rep_d      = bus.repeat_cnt;
          rd_ptr_d   = '0;
          lpass_d    = '0;
          pass_cnt_d = '0;
          state_d    = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (load) begin
          out_data_d = mem_q[rd_ptr_q];
          out_vld_d  = 1'b1;
          out_fst_d  = (rd_ptr_q == '0);
          out_lst_d  = at_last;
          if (at_last) begin
            rd_ptr_d = '0;
            lpass_d  = lpass_q + CNTW'(1);
            // Finite mode: the final word is now in the output register
            if ((rep_q != '0) && (lpass_q + CNTW'(1) == rep_q)) state_d = ST_DRAIN;
          end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (xfer) begin
          done_d    = 1'b1;
          out_vld_d = 1'b0;
          out_fst_d = 1'b0;
          out_lst_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.abort) begin
      state_d   = ST_IDLE;
      out_vld_d = 1'b0;
      out_fst_d = 1'b0;
      out_lst_d = 1'b0;
      done_d    = 1'b0;
    end
  end

  assign bus.out_data = out_data_q;
  assign bus.out_vld  = out_vld_q;
  assign bus.out_fst  = out_fst_q;
  assign bus.out_lst  = out_lst_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = done_q;
  assign bus.pass_cnt = pass_cnt_q;

endmodule
`default_nettype wire

// File: doc/nn_stream_player.md
# nn_stream_player

Parametrised, synthesizable stream source for the neural datapath test and bring-up flow. It holds a loadable buffer of `WIDTH`-bit words and replays the first `length` words as a valid/ready stream, with first/last markers, a programmable pass count or continuous mode, backpressure and abort. It sits in front of a layer's data or expected-value input, in place of hand-written per-test replay counters, so the same block drives fixed-length or endless traffic into any stage.

## Interface

Parameters:
- `WIDTH`, 32: data word width (float_24_8 payload by default).
- `DEPTH`, 64: buffer depth in words; `AW = $clog2(DEPTH)` is derived and not overridable.
- `CNTW`, 16: width of the pass counter and `repeat_cnt`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_vld`  in  1  buffer write strobe.
- `wr_addr`  in  AW  buffer write address.
- `wr_data`  in  WIDTH  buffer write data.
- `start`  in  1  begin playback; sampled in IDLE only.
- `abort`  in  1  stop playback immediately.
- `length`  in  AW+1  words per pass; valid range 1..DEPTH.
- `repeat_cnt`  in  CNTW  passes to play; 0 means continuous.
- `out_data`  out  WIDTH  stream data.
- `out_vld`  out  1  stream valid.
- `out_rdy`  in  1  stream ready.
- `out_fst`  out  1  marks word 0 of each pass.
- `out_lst`  out  1  marks word `length-1` of each pass.
- `busy`  out  1  high in PLAY and DRAIN.
- `done`  out  1  one-cycle pulse when the final word of the final pass is accepted.
- `pass_cnt`  out  CNTW  passes completed, counted as `out_lst` words accepted.

## Operation

- Buffer: `DEPTH x WIDTH` single write port and single read port. A write is accepted in any state. A read and a write to the same address in the same cycle return the old data.
- Transfer: a word transfers when `out_vld & out_rdy`. The output register loads when `!out_vld | out_rdy`.
- States:
  - IDLE: on `start` with `1 <= length <= DEPTH`, latch `length` and `repeat_cnt`, clear `rd_ptr` and `pass_cnt`, go to PLAY. A `start` with an out-of-range `length` is ignored.
  - PLAY: on each output-register load:
    - load `buf[rd_ptr]`; `out_fst = (rd_ptr == 0)`; `out_lst = (rd_ptr == len-1)`.
    - `rd_ptr` wraps from `len-1` to 0.
    - When the loaded word is the last word of pass `repeat_cnt` (finite mode), go to DRAIN.
  - DRAIN: on the transfer of that word, pulse `done`, clear `out_vld`, go to IDLE.
- Ignored inputs: `start` in PLAY or DRAIN is ignored. Changes to `length` or `repeat_cnt` after start have no effect.
- Abort: `abort` in any state clears `out_vld`, `out_fst` and `out_lst` at the next edge and returns to IDLE. No `done` pulse. `pass_cnt` holds its value.
- Pass counter: `pass_cnt` increments on each transfer with `out_lst`. In continuous mode it wraps modulo `2^CNTW`.
- `length == 1`: `out_fst` and `out_lst` are both high on every word.
- Stall: while `out_vld & !out_rdy`, `out_data`, `out_fst` and `out_lst` hold stable.

## Timing

- Reset values: all outputs 0 (`out_data`, `out_vld`, `out_fst`, `out_lst`, `busy`, `done`, `pass_cnt`); state IDLE; `rd_ptr` 0. Buffer contents are not reset.
- Reset asserted mid-playback clears all outputs asynchronously, without waiting for a clock edge.
- `start` sampled at edge t: `busy` is high after edge t, and the first `out_vld` is high after edge t+1 (latency 2).
- Throughput: one word per cycle while `out_rdy` stays high; no bubbles at pass wrap.
- `done` is high for exactly the cycle after the final transfer edge. `busy` falls on that same edge.
- `start` may be accepted in the cycle `done` is high (back-to-back runs).
- `abort` and a transfer in the same cycle: the transfer counts toward `pass_cnt`; abort still wins the state.

## Test plan

- Single pass:
  - Stimulus: load words 0..7, `length=8`, `repeat_cnt=1`, `out_rdy=1`.
  - Response: `out_data` 0..7 on consecutive cycles, `out_fst` on 0, `out_lst` on 7, `done` one cycle after the word-7 transfer, `pass_cnt=1`, `busy` low afterwards.
- Multi-pass:
  - Stimulus: `length=5`, `repeat_cnt=3`.
  - Response: 15 words (0..4 three times), `out_fst` asserted 3 times, `pass_cnt` steps 1, 2, 3, one `done` pulse.
- Backpressure:
  - Stimulus: `out_rdy` random at 50%, `length=8`, `repeat_cnt=2`.
  - Response: the accepted sequence is identical to the `out_rdy=1` case, and outputs never change during stalls.
- Continuous and abort:
  - Stimulus: `repeat_cnt=0`, `length=3`; run 100 transfers, then assert `abort`.
  - Response: `out_vld` low on the next cycle, no `done`, `pass_cnt=33`, `busy` low.
- Illegal and ignored start:
  - Stimulus: `start` with `length=0` or `length=DEPTH+1`; `start` while busy.
  - Response: no state change and no output activity; the running pass is undisturbed.
- Edge cases:
  - Stimulus 1: `length=1`, `repeat_cnt=4`.
    - Response: 4 words, each with `out_fst` and `out_lst` high.
  - Stimulus 2: assert `reset` asynchronously mid-run.
    - Response: all outputs 0 before the next edge.
  - Stimulus 3: write to the address being read in the same cycle.
    - Response: the old word is streamed.
